// File: rtl/rns_fwd_conv_if.sv
// Streaming bus for the RNS forward converter: signed binary word in, residue triple out.
// master = producer/consumer side, slave = converter side.
interface rns_fwd_conv_if #(
   parameter int N = 5
);
   // Handshake: a word moves on a rising clock edge when valid & ready are both high.
   // A source holds valid and its data steady until that edge. The converter holds
   // out_valid and the residues steady while out_ready is low.
   logic              in_valid;
   logic              in_ready;
   logic [3*N-1:0]    in_data;
   logic              out_valid;
   logic              out_ready;
   logic [N:0]        r_p1;
   logic [N-1:0]      r_p0;
   logic [N-1:0]      r_m1;
   logic              range_err;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  r_p1,
      input  r_p0,
      input  r_m1,
      input  range_err
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output r_p1,
      output r_p0,
      output r_m1,
      output range_err
   );
endinterface

// File: rtl/rns_fwd_conv.sv
// Two-stage forward converter: signed 3N-bit X -> residues mod {2^N+1, 2^N, 2^N-1}.
// Optional range check enabled by defining RNS_FWD_RANGE_CHK_EN.
module rns_fwd_conv #(
   parameter int N = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   rns_fwd_conv_if.slave    bus
);

   localparam int W  = 3 * N;
   localparam int PW = N + 3;

   localparam logic signed [PW-1:0] MOD_P1 = PW'(2**N + 1);
   localparam logic [N:0]           P1_TOP = (N+1)'(2**N);
   localparam logic [N-1:0]         ALL1   = '1;
   localparam logic [N-1:0]         M1_TOP = ALL1 - N'(1);

   // ------------------------------------------------------------------
   // Flow control
   // ------------------------------------------------------------------
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic stall;
   logic s1_load;
   logic s2_load;

   assign stall        = s2_valid_q & ~bus.out_ready;
   assign bus.in_ready = ~(s1_valid_q & stall);
   assign s1_load      = bus.in_valid & bus.in_ready;
   assign s2_load      = ~stall & s1_valid_q;

   // in_ready high means S1 is either empty or moving into S2 this edge.
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (bus.in_ready) begin
         s1_valid_d = bus.in_valid;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      if (!stall) begin
         s2_valid_d = s1_valid_q;
      end
   end

   // ------------------------------------------------------------------
   // Stage S1: chunk folding on the unsigned bit pattern
   // ------------------------------------------------------------------
   logic [N-1:0]         u0, u1, u2;
   logic [N+1:0]         sum_m1;
   logic [N:0]           fold_m1;
   logic [N-1:0]         a_m1_d;
   logic signed [PW-1:0] t_p1;
   logic signed [PW-1:0] adj_p1;
   logic [N:0]           a_p1_d;
   logic [N-1:0]         a_p0_d;
   logic                 sign_d;
   logic                 oor_d;

   assign {u2, u1, u0} = bus.in_data;
   assign a_p0_d       = u0;
   assign sign_d       = bus.in_data[W-1];

   // Two end-around folds bring the three-chunk sum back into N bits;
   // the all-ones result is a second encoding of zero, cleaned up in S2.
   always_comb begin
      sum_m1  = {2'b00, u0} + {2'b00, u1} + {2'b00, u2};
      fold_m1 = {1'b0, sum_m1[N-1:0]} + {{(N-1){1'b0}}, sum_m1[N+1:N]};
      a_m1_d  = fold_m1[N-1:0] + {{(N-1){1'b0}}, fold_m1[N]};
   end

   // u0 - u1 + u2 spans -(2^N-1) .. 2^(N+1)-2, so one conditional add or
   // subtract of the modulus is enough.
   always_comb begin
      t_p1   = $signed({3'b000, u0}) + $signed({3'b000, u2}) - $signed({3'b000, u1});
      adj_p1 = t_p1;
      if (t_p1[PW-1]) begin
         adj_p1 = t_p1 + MOD_P1;
      end else if (t_p1 >= MOD_P1) begin
         adj_p1 = t_p1 - MOD_P1;
      end
      a_p1_d = (N+1)'(adj_p1);
   end

`ifdef RNS_FWD_RANGE_CHK_EN
   // Legal X spans -M/2 .. M/2-1 with M/2 = 2^(3N-1) - 2^(N-1).
   localparam logic [W-1:0]        HALF_M = (W'(1) << (W-1)) - (W'(1) << (N-1));
   localparam logic signed [W-1:0] LIM_HI = $signed(HALF_M - W'(1));
   localparam logic signed [W-1:0] LIM_LO = $signed(-HALF_M);

   assign oor_d = ($signed(bus.in_data) > LIM_HI) || ($signed(bus.in_data) < LIM_LO);
`else
   assign oor_d = 1'b0;
`endif

   logic [N-1:0] s1_a_m1_q;
   logic [N:0]   s1_a_p1_q;
   logic [N-1:0] s1_a_p0_q;
   logic         s1_sign_q;
   logic         s1_oor_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_m1_q  <= '0;
         s1_a_p1_q  <= '0;
         s1_a_p0_q  <= '0;
         s1_sign_q  <= 1'b0;
         s1_oor_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_load) begin
            s1_a_m1_q <= a_m1_d;
            s1_a_p1_q <= a_p1_d;
            s1_a_p0_q <= a_p0_d;
            s1_sign_q <= sign_d;
            s1_oor_q  <= oor_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage S2: negative correction, since X = U - 2^3N when the sign bit is set
   // ------------------------------------------------------------------
   logic [N-1:0] r_m1_d;
   logic [N:0]   r_p1_d;
   logic [N-1:0] r_p0_d;
   logic         range_err_d;

   always_comb begin
      r_m1_d = s1_a_m1_q;
      if (s1_sign_q) begin
         r_m1_d = (s1_a_m1_q == '0) ? M1_TOP : s1_a_m1_q - N'(1);
      end else if (s1_a_m1_q == ALL1) begin
         r_m1_d = '0;
      end
   end

   always_comb begin
      r_p1_d = s1_a_p1_q;
      if (s1_sign_q) begin
         r_p1_d = (s1_a_p1_q == P1_TOP) ? '0 : s1_a_p1_q + (N+1)'(1);
      end
   end

   assign r_p0_d      = s1_a_p0_q;
   assign range_err_d = s1_oor_q;

   logic [N:0]   r_p1_q;
   logic [N-1:0] r_p0_q;
   logic [N-1:0] r_m1_q;
   logic         range_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_q  <= 1'b0;
         r_p1_q      <= '0;
         r_p0_q      <= '0;
         r_m1_q      <= '0;
         range_err_q <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            r_p1_q      <= r_p1_d;
            r_p0_q      <= r_p0_d;
            r_m1_q      <= r_m1_d;
            range_err_q <= range_err_d;
         end
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.r_p1      = r_p1_q;
   assign bus.r_p0      = r_p0_q;
   assign bus.r_m1      = r_m1_q;
   assign bus.range_err = range_err_q;

   // ------------------------------------------------------------------
   // Embedded properties
   // ------------------------------------------------------------------
   a_p1_below_mod: assert property (@(posedge clk) disable iff (!rst_n)
      s2_valid_q |-> (r_p1_q <= P1_TOP));

   a_m1_not_all_ones: assert property (@(posedge clk) disable iff (!rst_n)
      s2_valid_q |-> (r_m1_q != ALL1));

   a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
      stall |=> (s2_valid_q && $stable({r_p1_q, r_p0_q, r_m1_q, range_err_q})));

endmodule

// File: tb/tb_rns_fwd_conv.sv
// Scoreboard bench for rns_fwd_conv: reference residues from integer modulo arithmetic.
module tb_rns_fwd_conv;

  localparam int N  = 5;
  localparam int W  = 3 * N;
  localparam int EW = 3 * N + 2;
  localparam longint HALF = (longint'(1) << (W - 1)) - (longint'(1) << (N - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rns_fwd_conv_if #(.N(N)) bus ();

  rns_fwd_conv #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int inflight = 0;
  bit rand_ready = 1'b0;
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [W-1:0] d);
    longint x, mp1, mp0, mm1, rp1, rp0, rm1;
    logic re;
    x   = longint'($signed(d));
    mp1 = (longint'(1) << N) + 1;
    mp0 = (longint'(1) << N);
    mm1 = (longint'(1) << N) - 1;
    rp1 = ((x % mp1) + mp1) % mp1;
    rp0 = ((x % mp0) + mp0) % mp0;
    rm1 = ((x % mm1) + mm1) % mm1;
`ifdef RNS_FWD_RANGE_CHK_EN
    re = (x < -HALF) || (x > HALF - 1);
`else
    re = 1'b0;
`endif
    return {re, rp1[N:0], rp0[N-1:0], rm1[N-1:0]};
  endfunction

  function automatic void check(input string name, input logic [EW-1:0] act,
                                input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [EW-1:0] dut_out();
    return {bus.range_err, bus.r_p1, bus.r_p0, bus.r_m1};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight   = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", EW'(bus.in_ready), EW'(!(inflight == 2 && !bus.out_ready)));
      if (prev_stall) begin
        check("hold_valid", EW'(bus.out_valid), EW'(1));
        check("hold_data", dut_out(), prev_out);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h, required no output", dut_out());
        end else begin
          check("residues", dut_out(), exp_q.pop_front());
        end
      end
      inflight += int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = dut_out();
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x);
    bit ok = 1'b0;
    int n  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back(model(x));
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready low for %0d cycles, required accept", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  function automatic logic [W-1:0] rand_x();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0:       return W'(HALF - 1 - longint'($urandom_range(0, 2)));
      1:       return W'(-HALF + longint'($urandom_range(0, 2)) - 1);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [W-1:0] dir_vec[7];
  int t0;

  initial begin
    dir_vec[0] = W'(-1);
    dir_vec[1] = W'(0);
    dir_vec[2] = W'(16367);
    dir_vec[3] = W'(-16368);
    dir_vec[4] = W'(16368);
    dir_vec[5] = W'(-16369);
    dir_vec[6] = W'(-16384);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", EW'(bus.out_valid), EW'(0));
    check("reset_outputs", dut_out(), '0);
    check("reset_in_ready", EW'(bus.in_ready), EW'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: accepted on one edge, visible after the following edge
    send(W'(100));
    bus.in_valid = 1'b0;
    check("latency_s1", EW'(bus.out_valid), EW'(0));
    @(posedge clk);
    #1;
    check("latency_s2", EW'(bus.out_valid), EW'(1));
    drain();

    foreach (dir_vec[i]) send(dir_vec[i]);
    drain();

    // throughput with out_ready held high
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(rand_x());
    check("throughput_cycles", EW'(cyc - t0), EW'(8));
    drain();

    // random backpressure with random input gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(rand_x());
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;

    // reset with two words in flight
    bus.out_ready = 1'b0;
    send(rand_x());
    send(rand_x());
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out_valid", EW'(bus.out_valid), EW'(0));
    check("midreset_outputs", dut_out(), '0);
    exp_q.delete();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", EW'(bus.out_valid), EW'(0));
    send(W'(-1));
    send(W'(100));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rns_fwd_conv.md
Name: rns_fwd_conv

Overview:
- Pipelined forward converter: signed two's-complement binary in, residue triple out, for moduli {2^n+1, 2^n, 2^n-1}.
- It is the encoding counterpart of the RNS sign-detection path. Residues it emits feed the RNS datapath, whose outputs are later sign-checked.
- Valid/ready streaming on both sides; 2-stage pipeline with full backpressure.

Parameters:
- N, 5, modulus exponent n; moduli 2^N+1, 2^N, 2^N-1; N >= 3.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  converter can accept in_data this cycle
- in_data  input  3N  signed two's-complement X
- out_valid  output  1  residue triple valid
- out_ready  input  1  downstream accepts triple
- r_p1  output  N+1  X mod (2^N+1), range 0..2^N
- r_p0  output  N  X mod 2^N
- r_m1  output  N  X mod (2^N-1), range 0..2^N-2; the all-ones code is never emitted
- range_err  output  1  qualified by out_valid; X outside dynamic range (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: every stage valid = 0, out_valid = 0, r_p1/r_p0/r_m1 = 0, range_err = 0. Reset asserted mid-stream discards all in-flight words; none are emitted after reset.
- Dynamic range M = 2^N*(2^2N - 1). Legal X: -M/2 .. M/2-1. For N=5: -16368..16367.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_data and range_err hold stable while out_valid & !out_ready.
- Pipeline: stage S1 register, then stage S2 (output register). Latency is exactly 2 cycles from input transfer to out_valid, with no stalls.
- Stall condition: stall = out_valid & !out_ready.
  - in_ready = !(S1 valid & stall).
  - S1 advances when S2 is empty or draining.
  - Throughput is 1 word/cycle with out_ready held high.
- Stage S1, with U = in_data taken unsigned and split into N-bit chunks u2:u1:u0:
  - a_m1 = u0+u1+u2, folded with end-around carry.
  - a_p1 = u0 - u1 + u2, taken mod 2^N+1.
  - a_p0 = u0.
  - Register the sign bit s = in_data[3N-1] alongside.
- Stage S2, negative correction. Because 2^3N ≡ 1 (mod 2^N-1), 0 (mod 2^N) and -1 (mod 2^N+1), when s = 1:
  - r_m1 = (a_m1 - 1) mod (2^N-1)
  - r_p0 = a_p0
  - r_p1 = (a_p1 + 1) mod (2^N+1)
  - When s = 0, S1 values pass through.
  - Final r_m1 normalises all-ones to 0.
- Arithmetic width rules:
  - The modular sum for 2^N+1 uses at least N+3 bits internally, so the signed intermediate cannot overflow.
  - All final residues are strictly below their modulus.
- No combinational path from in_data to outputs. in_ready depends only on registered state and out_ready.
- Simultaneous events:
  - Input accept and output drain in the same cycle with a full pipe: both occur, no word is lost or duplicated.
  - in_valid while !in_ready: the word is not taken, and the source must hold it.

Optional Feature:
- Macro RNS_FWD_RANGE_CHK_EN.
- Defined:
  - S1 compares in_data with the signed limits -M/2 and M/2-1.
  - range_err is pipelined with the data and asserts with out_valid for an illegal X.
  - Residues for an illegal X are still computed per the formulas above.
- Undefined: no comparator is built, and range_err is tied to 0.

Test Plan:
- Reset, then X=100, out_ready=1 -> out_valid at cycle 2 with r_p1=1, r_p0=4, r_m1=7, range_err=0.
- X=-1 -> r_p1=32, r_p0=31, r_m1=30. X=0 -> all residues 0; r_m1 never 31.
- Boundaries: X=16367 -> (32, 15, 30). X=-16368 -> (0, 16, 0). Both give range_err=0.
- Range check with macro on: X=16368 and X=-16369 -> range_err=1. Macro off -> range_err=0 for both.
- Backpressure: stream 8 words with out_ready toggling randomly.
  - Outputs appear in order with no loss or duplication.
  - Data stays stable during stalls.
  - in_ready drops only when S1 is full and the output is stalled.
  - Sustains 1 word/cycle with out_ready=1.
- Assert rst_n=0 with 2 words in flight -> next cycle out_valid=0 and all outputs 0. After release, the first emitted triple belongs to the first post-reset input.
